// File: rtl/irq_arbiter.sv
// Fixed-priority interrupt arbiter with memory-mapped ENABLE/PENDING/MODE/ACTIVE registers.
// Optional software trigger register at offset 4 when IRQ_ARBITER_SWTRIG_EN is defined.
module irq_arbiter #(
  parameter int unsigned NUM_SRC        = 8,
  parameter logic [15:0] BASE_ADDR      = 16'h1010,
  parameter int unsigned HOLDOFF_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] src_irq,
  input  logic [15:0]        io_address,
  input  logic [7:0]         io_wdata,
  input  logic               io_we,
  input  logic               io_re,
  output logic [7:0]         io_rdata,
  output logic               cpu_irq,
  input  logic               cpu_irq_clr
);

  localparam logic [7:0] SRC_MASK  = 8'((9'd1 << NUM_SRC) - 9'd1);
  localparam logic [3:0] HOLD_INIT = 4'(HOLDOFF_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ASSERT,
    S_HOLDOFF
  } state_e;

  state_e     state_q;
  logic [7:0] en_q, pend_q, mode_q, src_q, rdata_q;
  logic [2:0] active_id_q;
  logic       active_valid_q;
  logic       irq_q;
  logic [3:0] hold_q;

  logic [7:0] src_ext, en_d, mode_d, pend_d, pend_set, pend_clr, req, rd_val;
  logic [2:0] win_id;
  logic       sel_en, sel_pend, sel_mode, sel_act, ack, withdraw;

  assign src_ext  = 8'(src_irq) & SRC_MASK;
  assign sel_en   = (io_address == BASE_ADDR);
  assign sel_pend = (io_address == BASE_ADDR + 16'd1);
  assign sel_mode = (io_address == BASE_ADDR + 16'd2);
  assign sel_act  = (io_address == BASE_ADDR + 16'd3);
`ifdef IRQ_ARBITER_SWTRIG_EN
  logic sel_sw;
  assign sel_sw   = (io_address == BASE_ADDR + 16'd4);
`endif

  always_comb begin
    en_d   = en_q;
    mode_d = mode_q;
    if (io_we && sel_en)   en_d   = io_wdata & SRC_MASK;
    if (io_we && sel_mode) mode_d = io_wdata & SRC_MASK;

    pend_set = (src_ext & ~src_q & mode_q) | (src_ext & ~mode_q);
`ifdef IRQ_ARBITER_SWTRIG_EN
    if (io_we && sel_sw) pend_set = pend_set | io_wdata;
`endif
    pend_clr = '0;
    if (io_we && sel_pend) pend_clr = io_wdata;
    ack = (state_q == S_ASSERT) && cpu_irq_clr;
    if (ack) pend_clr[active_id_q] = 1'b1;
    // set terms are OR'd after the clear so a same-cycle set wins
    pend_d = ((pend_q & ~pend_clr) | pend_set) & SRC_MASK;

    // withdraw looks at next-state values so the request drops at the write edge
    withdraw = !en_d[active_id_q] || !pend_d[active_id_q];

    req    = pend_q & en_q;
    win_id = '0;
    for (int unsigned i = 8; i > 0; i--) begin
      if (req[i-1]) win_id = 3'(i - 1);
    end

    rd_val = '0;
    if (sel_en)   rd_val = en_q;
    if (sel_pend) rd_val = pend_q;
    if (sel_mode) rd_val = mode_q;
    if (sel_act)  rd_val = {active_valid_q, 4'b0000, active_id_q};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      en_q           <= '0;
      pend_q         <= '0;
      mode_q         <= '0;
      src_q          <= '0;
      rdata_q        <= '0;
      active_id_q    <= '0;
      active_valid_q <= 1'b0;
      irq_q          <= 1'b0;
      hold_q         <= '0;
    end else begin
      en_q   <= en_d;
      mode_q <= mode_d;
      pend_q <= pend_d;
      src_q  <= src_ext;
      if (io_re) rdata_q <= rd_val;

      case (state_q)
        S_IDLE: begin
          if (|req) begin
            active_id_q    <= win_id;
            active_valid_q <= 1'b1;
            irq_q          <= 1'b1;
            state_q        <= S_ASSERT;
          end else begin
            active_id_q    <= '0;
            active_valid_q <= 1'b0;
          end
        end
        S_ASSERT: begin
          if (cpu_irq_clr) begin
            irq_q   <= 1'b0;
            hold_q  <= HOLD_INIT;
            state_q <= S_HOLDOFF;
          end else if (withdraw) begin
            irq_q          <= 1'b0;
            active_valid_q <= 1'b0;
            active_id_q    <= '0;
            state_q        <= S_IDLE;
          end
        end
        S_HOLDOFF: begin
          hold_q <= hold_q - 4'd1;
          if (hold_q <= 4'd1) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign io_rdata = rdata_q;
  assign cpu_irq  = irq_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed bench for irq_arbiter with a cycle-level behavioural model checked every cycle.
module tb_irq_arbiter;

  localparam logic [15:0] BASE = 16'h1010;
  localparam int HOLD = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  src_irq;
  logic [15:0] io_address;
  logic [7:0]  io_wdata;
  logic        io_we, io_re;
  logic [7:0]  io_rdata;
  logic        cpu_irq;
  logic        cpu_irq_clr;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  irq_arbiter #(.NUM_SRC(8), .BASE_ADDR(BASE), .HOLDOFF_CYCLES(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .src_irq(src_irq), .io_address(io_address),
    .io_wdata(io_wdata), .io_we(io_we), .io_re(io_re), .io_rdata(io_rdata),
    .cpu_irq(cpu_irq), .cpu_irq_clr(cpu_irq_clr)
  );

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
  endtask

  // Model: the request line is either busy with one source, counting down a gap, or free to pick.
  bit [7:0] m_en, m_pend, m_mode, m_prev, m_rdata, np, ne, nm;
  bit       m_irq, m_valid, m_ok, ack, s_b, c_b;
  int       m_id, m_gap, w;

  function automatic bit [7:0] m_read(input logic [15:0] a);
    if (a == BASE)      return m_en;
    if (a == BASE + 1)  return m_pend;
    if (a == BASE + 2)  return m_mode;
    if (a == BASE + 3)  return {m_valid, 4'b0000, 3'(m_id)};
    return 8'h00;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_en = 0; m_pend = 0; m_mode = 0; m_prev = 0; m_rdata = 0;
      m_irq = 0; m_valid = 0; m_id = 0; m_gap = 0; m_ok = 1;
    end else begin
      if (io_re) m_rdata = m_read(io_address);
      ack = m_irq && cpu_irq_clr;
      for (int i = 0; i < 8; i++) begin
        s_b = m_mode[i] ? (src_irq[i] && !m_prev[i]) : src_irq[i];
`ifdef IRQ_ARBITER_SWTRIG_EN
        if (io_we && io_address == BASE + 4 && io_wdata[i]) s_b = 1;
`endif
        c_b = (io_we && io_address == BASE + 1 && io_wdata[i]) || (ack && m_id == i);
        np[i] = s_b || (m_pend[i] && !c_b);
      end
      ne = (io_we && io_address == BASE)     ? io_wdata : m_en;
      nm = (io_we && io_address == BASE + 2) ? io_wdata : m_mode;
      if (m_irq) begin
        if (ack) begin
          m_irq = 0; m_gap = HOLD;
        end else if (!ne[m_id] || !np[m_id]) begin
          m_irq = 0; m_valid = 0; m_id = 0;
        end
      end else if (m_gap > 0) begin
        m_gap--;
      end else begin
        w = -1;
        for (int i = 7; i >= 0; i--) if (m_pend[i] && m_en[i]) w = i;
        if (w >= 0) begin m_irq = 1; m_valid = 1; m_id = w; end
        else begin m_valid = 0; m_id = 0; end
      end
      m_en = ne; m_mode = nm; m_pend = np; m_prev = src_irq;
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      check("model_irq", {7'b0, cpu_irq}, {7'b0, m_irq});
      check("model_rdata", io_rdata, m_rdata);
    end
  end

  task automatic wr(input int off, input logic [7:0] d);
    io_address = BASE + 16'(off); io_wdata = d; io_we = 1;
    @(negedge clk);
    io_we = 0;
  endtask

  task automatic rd(input int off, input logic [7:0] exp, input string nm);
    io_address = BASE + 16'(off); io_re = 1;
    @(negedge clk);
    io_re = 0;
    check(nm, io_rdata, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_irq(input string nm);
    for (int n = 0; n < 20 && !cpu_irq; n++) @(negedge clk);
    check(nm, {7'b0, cpu_irq}, 8'h01);
  endtask

  task automatic clr_pulse();
    cpu_irq_clr = 1;
    @(negedge clk);
    cpu_irq_clr = 0;
  endtask

  initial begin
    rst_n = 0; src_irq = 0; io_address = 0; io_wdata = 0;
    io_we = 0; io_re = 0; cpu_irq_clr = 0;
    cyc(2);
    rst_n = 1;
    rd(0, 8'h00, "rst_enable");
    rd(1, 8'h00, "rst_pending");
    rd(2, 8'h00, "rst_mode");
    rd(3, 8'h00, "rst_active");
    rd(4, 8'h00, "rst_off4");
    check("rst_irq", {7'b0, cpu_irq}, 8'h00);

    // edge source 2: irq two cycles after the source's first high cycle
    wr(0, 8'h04); wr(2, 8'h04);
    src_irq = 8'h04;
    @(negedge clk);
    src_irq = 8'h00;
    check("edge_k1", {7'b0, cpu_irq}, 8'h00);
    @(negedge clk);
    check("edge_k2", {7'b0, cpu_irq}, 8'h01);
    rd(3, 8'h82, "edge_active");
    rd(1, 8'h04, "edge_pending");
    clr_pulse();
    check("edge_clr_low", {7'b0, cpu_irq}, 8'h00);
    rd(3, 8'h82, "edge_active_holdoff");
    rd(1, 8'h00, "edge_pending_clr");
    cyc(4);

    // simultaneous arrivals 1 and 5
    wr(0, 8'hFF); wr(2, 8'hFF);
    src_irq = 8'h22;
    @(negedge clk);
    src_irq = 8'h00;
    wait_irq("prio_first_irq");
    rd(3, 8'h81, "prio_active1");
    clr_pulse();
    check("prio_hold_a", {7'b0, cpu_irq}, 8'h00);
    @(negedge clk); check("prio_hold_b", {7'b0, cpu_irq}, 8'h00);
    @(negedge clk); check("prio_idle",   {7'b0, cpu_irq}, 8'h00);
    @(negedge clk); check("prio_reassert", {7'b0, cpu_irq}, 8'h01);
    rd(3, 8'h85, "prio_active5");
    clr_pulse();
    cyc(5);

    // level source 0 held high across a clear
    wr(2, 8'h00); wr(0, 8'h01);
    src_irq = 8'h01;
    wait_irq("lvl_irq");
    clr_pulse();
    check("lvl_clr_low", {7'b0, cpu_irq}, 8'h00);
    rd(1, 8'h01, "lvl_pending_kept");
    wait_irq("lvl_reassert");
    src_irq = 8'h00;
    wr(1, 8'h01);
    check("lvl_w1c_low", {7'b0, cpu_irq}, 8'h00);
    rd(1, 8'h00, "lvl_pending_clr");
    cyc(4);
    check("lvl_stays_low", {7'b0, cpu_irq}, 8'h00);

    // software withdraw of source 3 via ENABLE
    wr(2, 8'h08); wr(0, 8'h08);
    src_irq = 8'h08;
    @(negedge clk);
    src_irq = 8'h00;
    wait_irq("wd_irq");
    rd(3, 8'h83, "wd_active");
    wr(0, 8'h00);
    check("wd_low", {7'b0, cpu_irq}, 8'h00);
    rd(3, 8'h00, "wd_active_clr");
    clr_pulse();
    cyc(4);
    check("wd_clr_ignored", {7'b0, cpu_irq}, 8'h00);
    rd(1, 8'h08, "wd_pending_kept");

    wr(1, 8'h08);
    wr(0, 8'h10);
`ifdef IRQ_ARBITER_SWTRIG_EN
    wr(4, 8'h10);
    check("sw_pre", {7'b0, cpu_irq}, 8'h00);
    rd(1, 8'h10, "sw_pending");
    check("sw_irq", {7'b0, cpu_irq}, 8'h01);
    rd(3, 8'h84, "sw_active");
    clr_pulse();
    cyc(5);
`else
    wr(4, 8'h10);
    rd(4, 8'h00, "off4_reads0");
    rd(1, 8'h00, "off4_pending_unchanged");
    check("off4_no_irq", {7'b0, cpu_irq}, 8'h00);
`endif

    // reset while asserting
    wr(2, 8'h00); wr(0, 8'h40);
    src_irq = 8'h40;
    wait_irq("rstassert_irq");
    rst_n = 0;
    @(negedge clk);
    check("rstassert_low", {7'b0, cpu_irq}, 8'h00);
    src_irq = 8'h00;
    rst_n = 1;
    rd(0, 8'h00, "rstassert_enable");
    cyc(3);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
